// File: rtl/bmp_scan_ctrl.sv
// Bitmap scan controller: loads a bitmap into the bitmap register, then walks
// it as column slices followed by alternating top/bottom row-pair slices.
// Each slice is requested, awaited with a timeout, and handed to the ALU.
// All outputs come straight from flops. Request pulses appear in the cycle
// after the request state. State-decoded outputs such as busy, phase, done
// and err line up with the registered state.
module bmp_scan_ctrl #(
  parameter int NCOLS     = 24,
  parameter int NROWPAIRS = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       alustart,
  input  logic       colready,
  input  logic       rowtopready,
  input  logic       rowbotready,
  input  logic       finalcolumn,
  input  logic       alu_done,
  output logic       wren,
  output logic       nextcol,
  output logic       nextrowtop,
  output logic       nextrowbot,
  output logic       slice_valid,
  output logic [1:0] phase,
  output logic [5:0] slice_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [5:0]    NCOLS_L  = 6'(NCOLS);
  localparam logic [5:0]    NPAIR_L  = 6'(NROWPAIRS);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD      = 4'd1;
  localparam logic [3:0] S_LOAD_WAIT = 4'd2;
  localparam logic [3:0] S_COL_REQ   = 4'd3;
  localparam logic [3:0] S_COL_WAIT  = 4'd4;
  localparam logic [3:0] S_COL_ALU   = 4'd5;
  localparam logic [3:0] S_TOP_REQ   = 4'd6;
  localparam logic [3:0] S_TOP_WAIT  = 4'd7;
  localparam logic [3:0] S_TOP_ALU   = 4'd8;
  localparam logic [3:0] S_BOT_REQ   = 4'd9;
  localparam logic [3:0] S_BOT_WAIT  = 4'd10;
  localparam logic [3:0] S_BOT_ALU   = 4'd11;
  localparam logic [3:0] S_DONE      = 4'd12;
  localparam logic [3:0] S_ERR       = 4'd13;

  logic [3:0]    state_r, state_nxt_s;
  logic [5:0]    idx_r, idx_nxt_s;
  logic [TW-1:0] tmo_r, tmo_nxt_s;
  logic          wren_r, nextcol_r, nextrowtop_r, nextrowbot_r, slice_valid_r;
  logic          busy_r, done_r, err_r;
  logic [1:0]    phase_r, phase_nxt_s;
  logic          busy_nxt_s;

  // Next-state, slice index and timeout; the timeout count returns to zero whenever a wait state is left.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    tmo_nxt_s   = TW'(0);
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_LOAD;
        else       state_nxt_s = S_IDLE;
      end
      S_LOAD: begin
        state_nxt_s = S_LOAD_WAIT;
        idx_nxt_s   = 6'd0;
      end
      S_LOAD_WAIT: begin
        if (alustart) begin
          state_nxt_s = S_COL_REQ;
          idx_nxt_s   = 6'd0;
        end else if (tmo_r == TMO_LAST) begin
          state_nxt_s = S_ERR;
        end else begin
          tmo_nxt_s = tmo_r + TW'(1);
        end
      end
      S_COL_REQ: begin
        if (finalcolumn || (idx_r >= NCOLS_L)) begin
          state_nxt_s = S_TOP_REQ;
          idx_nxt_s   = 6'd0;
        end else begin
          state_nxt_s = S_COL_WAIT;
        end
      end
      S_COL_WAIT: begin
        if (colready)                 state_nxt_s = S_COL_ALU;
        else if (tmo_r == TMO_LAST)   state_nxt_s = S_ERR;
        else                          tmo_nxt_s   = tmo_r + TW'(1);
      end
      S_COL_ALU: begin
        if (alu_done) begin
          state_nxt_s = S_COL_REQ;
          idx_nxt_s   = idx_r + 6'd1;
        end else begin
          state_nxt_s = S_COL_ALU;
        end
      end
      S_TOP_REQ: state_nxt_s = S_TOP_WAIT;
      S_TOP_WAIT: begin
        if (rowtopready)              state_nxt_s = S_TOP_ALU;
        else if (tmo_r == TMO_LAST)   state_nxt_s = S_ERR;
        else                          tmo_nxt_s   = tmo_r + TW'(1);
      end
      S_TOP_ALU: begin
        if (alu_done) state_nxt_s = S_BOT_REQ;
        else          state_nxt_s = S_TOP_ALU;
      end
      S_BOT_REQ: state_nxt_s = S_BOT_WAIT;
      S_BOT_WAIT: begin
        if (rowbotready)              state_nxt_s = S_BOT_ALU;
        else if (tmo_r == TMO_LAST)   state_nxt_s = S_ERR;
        else                          tmo_nxt_s   = tmo_r + TW'(1);
      end
      S_BOT_ALU: begin
        if (alu_done) begin
          if ((idx_r + 6'd1) == NPAIR_L) begin
            state_nxt_s = S_DONE;
            idx_nxt_s   = 6'd0;
          end else begin
            state_nxt_s = S_TOP_REQ;
            idx_nxt_s   = idx_r + 6'd1;
          end
        end else begin
          state_nxt_s = S_BOT_ALU;
        end
      end
      S_DONE: state_nxt_s = S_IDLE;
      S_ERR: begin
        if (start) state_nxt_s = S_LOAD;
        else       state_nxt_s = S_ERR;
      end
      default: begin
        state_nxt_s = S_IDLE;
        idx_nxt_s   = 6'd0;
      end
    endcase
  end

  // Decode phase and busy from the upcoming state so the flopped copies align with the state register.
  always_comb begin
    phase_nxt_s = 2'd0;
    busy_nxt_s  = 1'b1;
    case (state_nxt_s)
      S_COL_REQ, S_COL_WAIT, S_COL_ALU: phase_nxt_s = 2'd1;
      S_TOP_REQ, S_TOP_WAIT, S_TOP_ALU: phase_nxt_s = 2'd2;
      S_BOT_REQ, S_BOT_WAIT, S_BOT_ALU: phase_nxt_s = 2'd3;
      default:                          phase_nxt_s = 2'd0;
    endcase
    case (state_nxt_s)
      S_IDLE, S_DONE, S_ERR: busy_nxt_s = 1'b0;
      default:               busy_nxt_s = 1'b1;
    endcase
  end

  // State, counters and all output flops; reset returns everything to idle with outputs low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      idx_r         <= 6'd0;
      tmo_r         <= TW'(0);
      wren_r        <= 1'b0;
      nextcol_r     <= 1'b0;
      nextrowtop_r  <= 1'b0;
      nextrowbot_r  <= 1'b0;
      slice_valid_r <= 1'b0;
      phase_r       <= 2'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      idx_r         <= idx_nxt_s;
      tmo_r         <= tmo_nxt_s;
      wren_r        <= (state_r == S_LOAD);
      nextcol_r     <= (state_r == S_COL_REQ) && (state_nxt_s == S_COL_WAIT);
      nextrowtop_r  <= (state_r == S_TOP_REQ);
      nextrowbot_r  <= (state_r == S_BOT_REQ);
      slice_valid_r <= ((state_r == S_COL_WAIT) && colready)    ||
                       ((state_r == S_TOP_WAIT) && rowtopready) ||
                       ((state_r == S_BOT_WAIT) && rowbotready);
      phase_r       <= phase_nxt_s;
      busy_r        <= busy_nxt_s;
      done_r        <= (state_nxt_s == S_DONE);
      err_r         <= (state_nxt_s == S_ERR);
    end
  end

  assign wren        = wren_r;
  assign nextcol     = nextcol_r;
  assign nextrowtop  = nextrowtop_r;
  assign nextrowbot  = nextrowbot_r;
  assign slice_valid = slice_valid_r;
  assign phase       = phase_r;
  assign slice_idx   = idx_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;

endmodule

// File: tb/tb_bmp_scan_ctrl.sv
// Directed bench for bmp_scan_ctrl. A small environment model answers each
// request one cycle later and counts the pulses it sees. Each scenario then
// compares those counts and sampled outputs with hand-computed values.
module tb_bmp_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, alustart, colready, rowtopready, rowbotready;
  logic       finalcolumn, alu_done;
  logic       wren, nextcol, nextrowtop, nextrowbot, slice_valid, busy, done, err;
  logic [1:0] phase;
  logic [5:0] slice_idx;
  logic [15:0] outs_s;

  int checks = 0;
  int errors = 0;

  int n_wren, n_col, n_top, n_bot, n_sv, n_done, excl_viol;
  int fc_after    = -1;
  int top_hold_at = 0;
  bit alu_hi      = 1'b0;
  bit hold_alu    = 1'b0;
  bit force_col   = 1'b0;
  bit alu_pend    = 1'b0;

  bmp_scan_ctrl #(.NCOLS(24), .NROWPAIRS(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .alustart(alustart),
    .colready(colready), .rowtopready(rowtopready), .rowbotready(rowbotready),
    .finalcolumn(finalcolumn), .alu_done(alu_done),
    .wren(wren), .nextcol(nextcol), .nextrowtop(nextrowtop), .nextrowbot(nextrowbot),
    .slice_valid(slice_valid), .phase(phase), .slice_idx(slice_idx),
    .busy(busy), .done(done), .err(err)
  );

  assign outs_s = {wren, nextcol, nextrowtop, nextrowbot, slice_valid, phase, slice_idx, busy, done, err};

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_wren = 0; n_col = 0; n_top = 0; n_bot = 0; n_sv = 0; n_done = 0;
  endtask

  // One clock: sample outputs after the edge, count pulses, set the environment's responses.
  task automatic tick();
    int nreq;
    @(posedge clk);
    #1;
    if (wren)        n_wren++;
    if (nextcol)     n_col++;
    if (nextrowtop)  n_top++;
    if (nextrowbot)  n_bot++;
    if (slice_valid) n_sv++;
    if (done)        n_done++;
    nreq = 0;
    if (wren)       nreq++;
    if (nextcol)    nreq++;
    if (nextrowtop) nreq++;
    if (nextrowbot) nreq++;
    if (nreq > 1) excl_viol++;
    alustart    = wren;
    colready    = nextcol | force_col;
    rowtopready = nextrowtop && (n_top != top_hold_at);
    rowbotready = nextrowbot;
    finalcolumn = ((fc_after >= 0) && (n_col >= fc_after)) ? 1'b1 : 1'b0;
    if (slice_valid) alu_pend = 1'b1;
    alu_done = alu_hi | (alu_pend & ~hold_alu);
    if (alu_done) alu_pend = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    int k = 0;
    while (n_done == 0 && k < 3000) begin
      tick();
      k++;
    end
    chk_val(tag, n_done, 1);
    tick();
  endtask

  initial begin
    int k;
    logic [5:0] saved_idx;
    int saved_sv;
    rst = 1'b1; start = 1'b0; alustart = 1'b0; colready = 1'b0;
    rowtopready = 1'b0; rowbotready = 1'b0; finalcolumn = 1'b0; alu_done = 1'b0;
    excl_viol = 0;
    clear_counts();

    // Reset state and quiet idle
    tick(); tick();
    rst = 1'b0;
    chk_val("rst_outs", 32'(outs_s), 0);
    repeat (8) tick();
    chk_val("idle_noreq", n_wren + n_col + n_top + n_bot, 0);
    chk_val("idle_busy", 32'(busy), 0);

    // Full scan
    clear_counts();
    pulse_start();
    chk_val("full_busy", 32'(busy), 1);
    run_to_done("full_done");
    chk_val("full_wren", n_wren, 1);
    chk_val("full_col", n_col, 24);
    chk_val("full_top", n_top, 32);
    chk_val("full_bot", n_bot, 32);
    chk_val("full_sv", n_sv, 88);
    chk_val("full_idle_busy", 32'(busy), 0);
    chk_val("full_idle_phase", 32'(phase), 0);
    repeat (3) tick();
    chk_val("full_done_once", n_done, 1);

    // finalcolumn after five columns
    clear_counts();
    fc_after = 5;
    pulse_start();
    k = 0;
    while (phase != 2'd2 && k < 500) begin tick(); k++; end
    chk_val("fc_ncol", n_col, 5);
    chk_val("fc_phase", 32'(phase), 2);
    chk_val("fc_idx", 32'(slice_idx), 0);
    run_to_done("fc_done");
    chk_val("fc_sv", n_sv, 69);
    chk_val("fc_col_final", n_col, 5);
    fc_after = -1;

    // Timeout in row pair 7
    clear_counts();
    top_hold_at = 8;
    pulse_start();
    k = 0;
    while (n_top < 8 && k < 2000) begin tick(); k++; end
    chk_val("to_reach", n_top, 8);
    repeat (15) tick();
    chk_val("to_err_early", 32'(err), 0);
    chk_val("to_busy_early", 32'(busy), 1);
    tick();
    chk_val("to_err", 32'(err), 1);
    chk_val("to_busy", 32'(busy), 0);
    repeat (5) tick();
    chk_val("to_err_sticky", 32'(err), 1);
    top_hold_at = 0;
    clear_counts();
    pulse_start();
    chk_val("to_err_clr", 32'(err), 0);
    tick();
    chk_val("to_wren", 32'(wren), 1);
    run_to_done("to_restart_done");
    chk_val("to_restart_sv", n_sv, 88);

    // Reset while in BOT_ALU of pair 10
    clear_counts();
    pulse_start();
    k = 0;
    while (!(slice_valid && phase == 2'd3 && n_bot == 11) && k < 2000) begin tick(); k++; end
    chk_val("rb_reach", n_bot, 11);
    rst = 1'b1;
    tick();
    chk_val("rb_outs", 32'(outs_s), 0);
    rst = 1'b0;
    alu_pend = 1'b0;
    alu_done = 1'b0;
    clear_counts();
    repeat (20) tick();
    chk_val("rb_noreq", n_wren + n_col + n_top + n_bot, 0);
    pulse_start();
    run_to_done("rb_restart_done");
    chk_val("rb_restart_bot", n_bot, 32);

    // Mid-scan start plus stray colready in TOP_ALU
    clear_counts();
    pulse_start();
    k = 0;
    while (!(slice_valid && phase == 2'd2 && n_top == 3) && k < 2000) begin tick(); k++; end
    chk_val("mid_reach", n_top, 3);
    alu_done  = 1'b0;
    alu_pend  = 1'b1;
    hold_alu  = 1'b1;
    saved_idx = slice_idx;
    saved_sv  = n_sv;
    start     = 1'b1;
    force_col = 1'b1;
    repeat (4) tick();
    chk_val("mid_phase", 32'(phase), 2);
    chk_val("mid_idx", 32'(slice_idx), 2);
    chk_val("mid_idx_hold", 32'(slice_idx), 32'(saved_idx));
    chk_val("mid_busy", 32'(busy), 1);
    chk_val("mid_sv", n_sv, saved_sv);
    chk_val("mid_wren", n_wren, 1);
    start     = 1'b0;
    force_col = 1'b0;
    hold_alu  = 1'b0;
    run_to_done("mid_done");
    chk_val("mid_wren_total", n_wren, 1);
    chk_val("mid_col", n_col, 24);
    chk_val("mid_top", n_top, 32);
    chk_val("mid_bot", n_bot, 32);
    chk_val("mid_sv_total", n_sv, 88);

    // alu_done held high throughout
    clear_counts();
    alu_hi = 1'b1;
    pulse_start();
    run_to_done("hi_done");
    chk_val("hi_sv", n_sv, 88);
    chk_val("hi_col", n_col, 24);
    chk_val("hi_top", n_top, 32);
    chk_val("hi_bot", n_bot, 32);
    alu_hi = 1'b0;

    chk_val("req_exclusive", excl_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bmp_scan_ctrl.md
BMP_SCAN_CTRL -- requirements
Module: bmp_scan_ctrl

Interface
REQ-001 SHALL have parameter NCOLS, default 24, number of column slices per bitmap.
REQ-002 SHALL have parameter NROWPAIRS, default 32, number of top/bottom row pairs per bitmap (64 rows total).
REQ-003 SHALL have parameter TIMEOUT, default 16, cycles allowed for a bitmap-register ready response.
REQ-004 SHALL have ports, listed as name  direction  width  meaning:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  new bitmap present on bitmap-register input; sampled in IDLE or ERR only.
- alustart  in  1  bitmap register load acknowledge.
- colready  in  1  column slice valid.
- rowtopready  in  1  top row slice valid.
- rowbotready  in  1  bottom row slice valid.
- finalcolumn  in  1  bitmap register reports no further column.
- alu_done  in  1  ALU finished with the current slice.
- wren  out  1  load pulse to bitmap register.
- nextcol  out  1  column request pulse.
- nextrowtop  out  1  top row request pulse.
- nextrowbot  out  1  bottom row request pulse.
- slice_valid  out  1  one-cycle pulse, slice ready for ALU.
- phase  out  2  0 idle, 1 columns, 2 top row, 3 bottom row.
- slice_idx  out  6  index of the current slice within its phase.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse, scan complete.
- err  out  1  sticky timeout flag.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, LOAD_WAIT, COL_REQ, COL_WAIT, COL_ALU, TOP_REQ, TOP_WAIT, TOP_ALU, BOT_REQ, BOT_WAIT, BOT_ALU, DONE, ERR.
REQ-006 SHALL move IDLE->LOAD on start=1; LOAD SHALL assert wren for exactly one cycle, then go to LOAD_WAIT.
REQ-007 In LOAD_WAIT, alustart=1 SHALL go to COL_REQ with slice_idx=0.
REQ-008 COL_REQ with finalcolumn=0 and slice_idx<NCOLS SHALL pulse nextcol for one cycle, then go to COL_WAIT.
REQ-009 COL_REQ with finalcolumn=1 or slice_idx==NCOLS SHALL issue no request, clear slice_idx, and go to TOP_REQ.
REQ-010 In COL_WAIT, colready=1 SHALL pulse slice_valid on the next cycle and go to COL_ALU; slice_valid latency from ready SHALL be exactly 1 cycle.
REQ-011 In COL_ALU, alu_done=1 SHALL increment slice_idx and return to COL_REQ.
REQ-012 TOP_REQ SHALL pulse nextrowtop, go to TOP_WAIT, then to TOP_ALU on rowtopready with slice_valid pulse. TOP_ALU SHALL go to BOT_REQ on alu_done.
REQ-013 BOT_REQ SHALL pulse nextrowbot, go to BOT_WAIT, then to BOT_ALU on rowbotready with slice_valid pulse.
REQ-014 BOT_ALU on alu_done SHALL increment slice_idx. If the result equals NROWPAIRS, go to DONE; otherwise go to TOP_REQ.
REQ-015 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-016 A timeout counter SHALL clear on entry to each *_WAIT state and LOAD_WAIT, and increment each cycle there. When it reaches TIMEOUT with no ready, the FSM SHALL go to ERR and set err=1.
REQ-017 ERR SHALL hold err=1 and busy=0. start=1 in ERR SHALL clear err and go to LOAD.
REQ-018 Ready inputs arriving outside their matching *_WAIT state SHALL be ignored. alu_done outside *_ALU states SHALL be ignored.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 Request pulses (wren, nextcol, nextrowtop, nextrowbot) SHALL be mutually exclusive, with at most one asserted per cycle.
REQ-021 busy SHALL be 1 in all states except IDLE, DONE and ERR.
REQ-022 phase SHALL be 1 in COL_*, 2 in TOP_*, 3 in BOT_*, and 0 elsewhere.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 rst=1 SHALL, on the next edge, force IDLE and clear all outputs, slice_idx and the timeout counter. This holds in any state, including mid-scan.
REQ-025 After rst deasserts, no request pulse SHALL occur until start=1.

Verification
REQ-026 Full scan: start, with alustart, each ready and alu_done each one cycle after its request -> 1 wren, 24 nextcol, 32 nextrowtop, 32 nextrowbot, 88 slice_valid, then one done pulse.
REQ-027 finalcolumn=1 after 5 columns -> exactly 5 nextcol pulses, then phase=2 and slice_idx=0.
REQ-028 rowtopready withheld in pair 7 -> err=1 and busy=0 at 16 cycles after entering TOP_WAIT; a following start clears err and issues wren.
REQ-029 rst asserted in BOT_ALU at pair 10 -> all outputs 0 the next cycle; no nextrowbot until the next start.
REQ-030 start pulsed mid-scan, plus colready asserted while in TOP_ALU -> no extra wren, no state change, counts unchanged.
REQ-031 alu_done held high continuously -> each slice advances only once per ready/alu_done cycle; done still arrives after exactly 88 slices.
